// File: rtl/zigzag_encryption_if.sv
// Character-stream bundle between a plaintext source and the zigzag encoder.
// The source drives characters and the rail count; the encoder returns
// busy plus the ciphertext stream.
interface zigzag_encryption_if #(
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 8
);
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic [KEY_WIDTH-1:0] key;
  logic                 busy;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;

  modport master (
    output data_i, valid_i, key,
    input  busy, data_o, valid_o
  );

  modport slave (
    input  data_i, valid_i, key,
    output busy, data_o, valid_o
  );
endinterface

// File: rtl/zigzag_encryption.sv
// Rail-fence (zigzag) encoder. Characters are buffered in LOAD until the
// start token arrives, then re-emitted one per cycle in zigzag order:
// rail by rail, walking each rail with its alternating step pair.
module zigzag_encryption #(
  parameter int D_WIDTH                = 8,
  parameter int KEY_WIDTH              = 8,
  parameter int MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = 8'hFA
) (
  input  logic clk_sys,
  input  logic rst_n,
  zigzag_encryption_if.slave bus
);

  // 16-bit index arithmetic: idx + 2*(k-1) cannot wrap even for k = 255.
  localparam int IW = 16;
  localparam int AW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;

  typedef enum logic {S_LOAD, S_EMIT} state_t;

  state_t               r_state, w_state_nxt;
  logic [D_WIDTH-1:0]   r_buf [MAX_NOF_CHARS];
  logic [IW-1:0]        r_count;
  logic [KEY_WIDTH-1:0] r_k;
  logic [IW-1:0]        r_rail;
  logic [IW-1:0]        r_idx;
  logic                 r_dir;   // middle rails: 0 -> next step is 2(k-1-r), 1 -> 2r
  logic                 r_done;  // last character sent; next edge returns to LOAD
  logic                 r_busy;
  logic                 r_valid_o;
  logic [D_WIDTH-1:0]   r_data_o;

  logic                 w_accept;
  logic                 w_start;
  logic                 w_emit;
  logic                 w_finish;
  logic [AW-1:0]        w_wr_addr;
  logic [IW-1:0]        w_k;
  logic [IW-1:0]        w_p;
  logic [IW-1:0]        w_step;
  logic [IW-1:0]        w_next_idx;
  logic [IW-1:0]        w_rail_inc;
  logic                 w_last_rail;
  logic                 w_is_token;

  assign bus.busy    = r_busy;
  assign bus.valid_o = r_valid_o;
  assign bus.data_o  = r_data_o;

  assign w_is_token = (bus.data_i == START_ENCRYPTION_TOKEN);
  assign w_k        = IW'(r_k);
  assign w_p        = (w_k - IW'(1)) << 1;
  assign w_rail_inc = r_rail + IW'(1);
  assign w_next_idx = r_idx + w_step;

  // Step to the next index on the current rail.
  always_comb begin
    w_step = IW'(1);
    if (w_k < IW'(2))
      w_step = IW'(1);
    else if (r_rail == '0 || r_rail == w_k - IW'(1))
      w_step = w_p;
    else if (r_dir)
      w_step = r_rail << 1;
    else
      w_step = (w_k - IW'(1) - r_rail) << 1;
  end

  // Last rail that still owns characters: out of rails, or rails beyond count are empty.
  assign w_last_rail = (w_k < IW'(2)) || (w_rail_inc == w_k) || (w_rail_inc >= r_count);

  // Next-state and per-cycle actions.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    w_emit      = 1'b0;
    w_finish    = 1'b0;
    w_wr_addr   = r_count[AW-1:0];
    case (r_state)
      S_LOAD: begin
        if (bus.valid_i) begin
          if (w_is_token) begin
            if (r_count != '0) begin
              w_start     = 1'b1;
              w_state_nxt = S_EMIT;
            end
          end else if (r_count < IW'(MAX_NOF_CHARS)) begin
            w_accept = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (!r_done) begin
          w_emit = 1'b1;
        end else begin
          // Busy falls on this edge; a character arriving now opens the next message.
          w_finish    = 1'b1;
          w_state_nxt = S_LOAD;
          w_wr_addr   = '0;
          w_accept    = bus.valid_i && !w_is_token;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_LOAD;
      r_count   <= '0;
      r_k       <= '0;
      r_rail    <= '0;
      r_idx     <= '0;
      r_dir     <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid_o <= w_emit;
      if (w_start) begin
        r_k    <= bus.key;
        r_rail <= '0;
        r_idx  <= '0;
        r_dir  <= 1'b0;
        r_done <= 1'b0;
        r_busy <= 1'b1;
      end
      if (w_emit) begin
        r_data_o <= r_buf[r_idx[AW-1:0]];
        if (w_next_idx < r_count) begin
          r_idx <= w_next_idx;
          r_dir <= ~r_dir;
        end else if (w_last_rail) begin
          r_done <= 1'b1;
        end else begin
          r_rail <= w_rail_inc;
          r_idx  <= w_rail_inc;
          r_dir  <= 1'b0;
        end
      end
      if (w_finish) begin
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_count <= w_accept ? IW'(1) : '0;
      end else if (w_accept) begin
        r_count <= r_count + IW'(1);
      end
    end
  end

  // Character buffer; contents need no reset.
  always_ff @(posedge clk_sys) begin
    if (w_accept)
      r_buf[w_wr_addr] <= bus.data_i;
  end

endmodule

// File: tb/tb_zigzag_encryption.sv
// Bench for zigzag_encryption: directed messages plus random messages,
// checked cycle-by-cycle against a rail-fence reference model.
module tb_zigzag_encryption;

  localparam logic [7:0] TOKEN = 8'hFA;
  localparam int MAXC = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] q_msg[$];   // characters to drive for the next message
  logic [7:0] q_held[$];  // characters presented to the DUT for the current message
  logic [7:0] q_exp[$];   // expected ciphertext

  zigzag_encryption_if bif();

  zigzag_encryption dut (
    .clk_sys (clk),
    .rst_n   (rst_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Rail-fence reference: each position i lies on rail (i mod p) folded at k-1;
  // ciphertext lists rail 0 first, then rail 1, ..., each rail in index order.
  task automatic build_exp(input int k);
    int n, p, m, rr;
    q_exp.delete();
    n = (q_held.size() > MAXC) ? MAXC : q_held.size();
    if (k < 2) begin
      for (int i = 0; i < n; i++) q_exp.push_back(q_held[i]);
    end else begin
      p = 2 * (k - 1);
      for (int r = 0; r < k; r++)
        for (int i = 0; i < n; i++) begin
          m  = i % p;
          rr = (m < k) ? m : p - m;
          if (rr == r) q_exp.push_back(q_held[i]);
        end
    end
  endtask

  task automatic set_msg(input string s);
    q_msg.delete();
    for (int i = 0; i < s.len(); i++) q_msg.push_back(s[i]);
  endtask

  // Called at a falling edge; drives q_msg + token, then checks every output cycle.
  task automatic run_msg(input string tag, input int k, input logic inject,
                         input logic chain, input logic [7:0] chain_chr);
    foreach (q_msg[i]) begin
      bif.valid_i = 1'b1;
      bif.data_i  = q_msg[i];
      q_held.push_back(q_msg[i]);
      @(negedge clk);
    end
    bif.valid_i = 1'b1;
    bif.data_i  = TOKEN;
    bif.key     = 8'(k);
    @(negedge clk);
    bif.valid_i = 1'b0;
    bif.key     = 8'($urandom);
    build_exp(k);
    chk({tag, " busy_at_start"}, bif.busy, 1);
    chk({tag, " valid_at_start"}, bif.valid_o, 0);
    foreach (q_exp[i]) begin
      if (inject) begin
        bif.valid_i = 1'($urandom);
        bif.data_i  = ($urandom_range(0, 3) == 0) ? TOKEN : 8'($urandom);
      end
      @(negedge clk);
      chk($sformatf("%s valid[%0d]", tag, i), bif.valid_o, 1);
      chk($sformatf("%s data[%0d]", tag, i), bif.data_o, q_exp[i]);
      chk($sformatf("%s busy[%0d]", tag, i), bif.busy, 1);
    end
    bif.valid_i = chain;
    bif.data_i  = chain_chr;
    @(negedge clk);
    bif.valid_i = 1'b0;
    chk({tag, " busy_end"}, bif.busy, 0);
    chk({tag, " valid_end"}, bif.valid_o, 0);
    q_held.delete();
    if (chain) q_held.push_back(chain_chr);
  endtask

  initial begin
    bif.valid_i = 1'b0;
    bif.data_i  = '0;
    bif.key     = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", bif.busy, 0);
    chk("reset valid", bif.valid_o, 0);
    chk("reset data", bif.data_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    set_msg("ABCDEFG"); run_msg("k3_ABCDEFG", 3, 1'b0, 1'b0, 8'h00);
    set_msg("HELLO");   run_msg("k2_HELLO", 2, 1'b0, 1'b0, 8'h00);
    set_msg("HELLO");   run_msg("k1_HELLO", 1, 1'b0, 1'b0, 8'h00);
    set_msg("HELLO");   run_msg("k0_HELLO", 0, 1'b0, 1'b0, 8'h00);
    set_msg("HELLO");   run_msg("k9_HELLO", 9, 1'b0, 1'b0, 8'h00);

    // Token on an empty buffer is ignored.
    bif.valid_i = 1'b1;
    bif.data_i  = TOKEN;
    bif.key     = 8'd2;
    @(negedge clk);
    bif.valid_i = 1'b0;
    chk("empty_token busy", bif.busy, 0);
    chk("empty_token valid", bif.valid_o, 0);
    @(negedge clk);
    chk("empty_token busy2", bif.busy, 0);
    set_msg("AB"); run_msg("k2_AB", 2, 1'b0, 1'b0, 8'h00);

    // 52 characters: the buffer keeps only the first 50.
    q_msg.delete();
    for (int i = 0; i < 26; i++) q_msg.push_back(8'("a") + 8'(i));
    for (int i = 0; i < 26; i++) q_msg.push_back(8'("A") + 8'(i));
    run_msg("k4_overflow", 4, 1'b0, 1'b0, 8'h00);

    // Inputs during EMIT are ignored; next message starts clean.
    set_msg("INJECTED"); run_msg("k3_inject", 3, 1'b1, 1'b0, 8'h00);
    set_msg("CLEAN");    run_msg("k2_after_inject", 2, 1'b0, 1'b0, 8'h00);

    // A character presented on the edge busy falls belongs to the next message.
    set_msg("QRS");  run_msg("k2_chain_a", 2, 1'b0, 1'b1, 8'h4D);
    set_msg("NOPQ"); run_msg("k3_chain_b", 3, 1'b0, 1'b0, 8'h00);

    // Reset during the third output cycle.
    set_msg("0123456789");
    foreach (q_msg[i]) begin
      bif.valid_i = 1'b1;
      bif.data_i  = q_msg[i];
      q_held.push_back(q_msg[i]);
      @(negedge clk);
    end
    bif.valid_i = 1'b1;
    bif.data_i  = TOKEN;
    bif.key     = 8'd3;
    @(negedge clk);
    bif.valid_i = 1'b0;
    build_exp(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid data[%0d]", i), bif.data_o, q_exp[i]);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid busy", bif.busy, 0);
    chk("rst_mid valid", bif.valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q_held.delete();
    @(negedge clk);
    set_msg("XYZ"); run_msg("k2_XYZ", 2, 1'b0, 1'b0, 8'h00);

    // Random messages and keys.
    for (int t = 0; t < 12; t++) begin
      int len, k;
      len = $urandom_range(1, 55);
      k   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      q_msg.delete();
      for (int i = 0; i < len; i++) q_msg.push_back(8'($urandom_range(0, 249)));
      run_msg($sformatf("rand%0d_k%0d_n%0d", t, k, len), k, 1'($urandom), 1'b0, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
